imem_loader: RTL and testbench

- Write-side counterpart to the instruction fetch stage. Fetch reads 32-bit words from a 12-entry instruction memory by 4-bit PC.
- This block fills that memory at run time from a byte stream with a valid/ready handshake, replacing the static file preload.
- Assembles four bytes per word, big-endian, and issues one write per word at sequential addresses from 0.
- Raises done once INSTRUCTION_COUNT words are written. The core holds fetch (stage 0) off until done is high.

---
 rtl/imem_loader_if.sv | 47 ++++
 rtl/imem_loader.sv | 105 ++++++++++
 tb/tb_imem_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: bundles the byte-stream handshake and the instruction-memory
// write port of the instruction memory loader.
//   start, byte_valid, byte_data : stream source -> loader
//   byte_ready                   : loader -> stream source
//   wr_en, wr_addr, wr_data      : loader -> instruction memory write port
//   busy, done, word_count       : loader status
// modport slave is the loader side, modport master is the source/controller side.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  start;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] word_count;

    modport master (
        output start,
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  busy,
        input  done,
        input  word_count
    );

    modport slave (
        input  start,
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data,
        output busy,
        output done,
        output word_count
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory at run time from a byte stream.
// Four bytes per word, first byte is the MSB; one write per word at sequential
// addresses starting from 0. done rises once INSTRUCTION_COUNT words are written.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : imem_loader_if.slave (stream handshake, memory write port, status)
// All outputs come from registers or are decoded from the state register only.
module imem_loader #(
    parameter int unsigned INSTRUCTION_COUNT = 12,
    parameter int unsigned ADDR_WIDTH        = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    imem_loader_if.slave bus
);
    // One extra bit so a full 2**ADDR_WIDTH load can still be detected.
    localparam int unsigned CountWidth = ADDR_WIDTH + 1;
    localparam logic [CountWidth-1:0] CountLast = CountWidth'(INSTRUCTION_COUNT);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    // Bytes 0..2 of the word in progress; byte 3 goes straight into wr_data.
    logic [23:0]           word_buf_q, word_buf_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] word_count_q, word_count_d;
    logic [CountWidth-1:0] count_inc;

    assign count_inc = {1'b0, word_count_q} + CountWidth'(1);

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_buf_d   = word_buf_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d      = StCollect;
                    byte_idx_d   = 2'd0;
                    word_count_d = '0;
                end
            end
            StCollect: begin
                if (bus.byte_valid) begin
                    // Index wraps 3 -> 0 naturally when the word completes.
                    byte_idx_d = byte_idx_q + 2'd1;
                    unique case (byte_idx_q)
                        2'd0: word_buf_d[23:16] = bus.byte_data;
                        2'd1: word_buf_d[15:8]  = bus.byte_data;
                        2'd2: word_buf_d[7:0]   = bus.byte_data;
                        2'd3: begin
                            state_d   = StWrite;
                            wr_addr_d = word_count_q;
                            wr_data_d = {word_buf_q, bus.byte_data};
                        end
                        default: ;
                    endcase
                end
            end
            StWrite: begin
                word_count_d = count_inc[ADDR_WIDTH-1:0];
                state_d      = (count_inc == CountLast) ? StDone : StCollect;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            byte_idx_q   <= 2'd0;
            word_buf_q   <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_buf_q   <= word_buf_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.byte_ready = (state_q == StCollect);
    assign bus.wr_en      = (state_q == StWrite);
    assign bus.busy       = (state_q == StCollect) || (state_q == StWrite);
    assign bus.done       = (state_q == StDone);
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// The driver pushes each expected memory write (address = words sent so far in
// the current load, data = the word sent) into a scoreboard queue; a monitor
// pops and compares whenever wr_en is seen.
module tb_imem_loader;
    localparam int unsigned IC = 12;
    localparam int unsigned AW = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(
        .INSTRUCTION_COUNT(IC),
        .ADDR_WIDTH       (AW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks      = 0;
    int passed      = 0;
    int model_count = 0;
    int write_count = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clock) begin : monitor
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        if (reset_n && bus.wr_en === 1'b1) begin
            write_count++;
            if (exp_addr_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(ea));
                check("wr_data", bus.wr_data, ed);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_wr_data"}, bus.wr_data, 32'd0);
        check({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
    endtask

    // Entered and left at a negedge; start is seen at the posedge in between.
    task automatic pulse_start();
        bus.start   = 1'b1;
        model_count = 0;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    // Offers one byte after 'gap' idle cycles; returns at the negedge after the
    // accepting edge with byte_valid still high.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit last,
                             input logic [31:0] w);
        repeat (gap) begin
            bus.byte_valid = 1'b0;
            @(negedge clock);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int t = 0; bus.byte_ready !== 1'b1; t++) begin
            if (t >= 50) begin
                checks++;
                $display("FAIL byte_accept_timeout: got byte_ready=%0b, expected 1", bus.byte_ready);
                bus.byte_valid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        if (last) begin
            exp_addr_q.push_back(AW'(model_count));
            exp_data_q.push_back(w);
            model_count++;
        end
        @(negedge clock);
    endtask

    // gap < 0 selects a random 0..3 idle cycles before each byte.
    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            b = w[31-8*k -: 8];
            send_byte(b, (gap < 0) ? int'($urandom_range(3, 0)) : gap, k == 3, w);
        end
    endtask

    task automatic reset_mid_cycle();
        #2 reset_n = 1'b0;
        model_count = 0;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int w0;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;

        #3 check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("ready_before_start", 32'(bus.byte_ready), 32'd0);
        end
        bus.byte_valid = 1'b0;

        // Single word, back-to-back bytes, then held byte_valid across WRITE.
        pulse_start();
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("count_after_start", 32'(bus.word_count), 32'd0);
        send_word(32'h2001_0005, 0);
        check("write_latency_wr_en", 32'(bus.wr_en), 32'd1);
        check("ready_in_write", 32'(bus.byte_ready), 32'd0);
        bus.byte_data = 8'h11;
        @(negedge clock);
        check("wr_en_single_pulse", 32'(bus.wr_en), 32'd0);
        check("count_after_word0", 32'(bus.word_count), 32'd1);
        check("ready_after_write", 32'(bus.byte_ready), 32'd1);
        send_word(32'h1122_3344, 0);

        // Reset in the middle of word 3.
        send_word($urandom, -1);
        send_byte(8'h77, 0, 1'b0, 32'd0);
        send_byte(8'h66, 1, 1'b0, 32'd0);
        reset_mid_cycle();
        check("no_pending_after_reset", 32'(exp_addr_q.size()), 32'd0);
        check("ready_after_reset", 32'(bus.byte_ready), 32'd0);
        bus.byte_valid = 1'b0;
        pulse_start();
        send_word($urandom, -1);
        bus.byte_valid = 1'b0;
        @(negedge clock);

        // Full load, byte_valid toggling; start held (and ignored) mid-load.
        reset_mid_cycle();
        bus.byte_valid = 1'b0;
        pulse_start();
        w0 = write_count;
        for (int i = 0; i < int'(IC); i++) begin
            bus.start = (i >= 1 && i <= int'(IC) - 2);
            send_word(32'(i), 1);
        end
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        @(negedge clock);
        check("full_load_writes", 32'(write_count - w0), IC);
        check("done_after_load", 32'(bus.done), 32'd1);
        check("busy_after_load", 32'(bus.busy), 32'd0);
        check("count_after_load", 32'(bus.word_count), 32'(AW'(IC)));
        bus.byte_valid = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check("ready_in_done", 32'(bus.byte_ready), 32'd0);
        end
        bus.byte_valid = 1'b0;

        // Restart from DONE, then a random full load.
        pulse_start();
        check("done_drops_on_start", 32'(bus.done), 32'd0);
        check("count_clears_on_start", 32'(bus.word_count), 32'd0);
        send_word(32'hDEAD_BEEF, 0);
        for (int i = 1; i < int'(IC); i++) send_word($urandom, -1);
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("done_after_reload", 32'(bus.done), 32'd1);
        check("scoreboard_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
